dap_sclk_burst_gen: RTL and testbench

- Parametrised successor to the DAP serial-clock generator: programmable divider, programmable sample point, clock polarity, and a burst engine that emits exactly N clock periods and then flags done.
- Sits in DAP_Controller/interface between the AHB register window and the SWD/JTAG shift engines.
- Drives the GPIO clock pin plus setup/sample strobes for the engines.
- Single clock domain (clk); no separate sclk input.

---
 rtl/dap_sclk_burst_gen.sv | 197 +++++++++++++++++++
 tb/tb_dap_sclk_burst_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dap_sclk_burst_gen.sv
// Serial-clock generator with programmable divider, sample point, CPOL and N-period burst engine.
// Latency: register writes take effect next clk; first period starts the cycle after START; strobes align with sclk_out.
// Backpressure: none; register writes always complete, TIMING/COUNT writes are dropped while a burst is active.
module dap_sclk_burst_gen #(
    parameter int ADDRWIDTH = 12,
    parameter int BASE_ADDR = 0,
    parameter int DIV_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ahb_write_en,
    input  logic                 ahb_read_en,
    input  logic [ADDRWIDTH-1:0] ahb_addr,
    input  logic [31:0]          ahb_wdata,
    input  logic [3:0]           ahb_byte_strobe,
    output logic [31:0]          ahb_rdata,
    output logic                 sclk_out,
    output logic                 sclk_setup,
    output logic                 sclk_sample,
    output logic                 busy,
    output logic                 done
);

    localparam int WW = ADDRWIDTH - 2;
    localparam logic [ADDRWIDTH-1:0] BASE_VEC = ADDRWIDTH'(BASE_ADDR);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 en_q, en_d;
    logic                 cpol_q, cpol_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] sample_q, sample_d;
    logic [CNT_WIDTH-1:0] n_q, n_d;
    logic [CNT_WIDTH-1:0] rem_q, rem_d;
    logic [DIV_WIDTH:0]   cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 sclk_q, sclk_d;
    logic                 setup_q, setup_d;
    logic                 samp_q, samp_d;

    logic [WW-1:0] widx;
    logic          sel_cr, sel_timing, sel_count, sel_status;
    logic          wr_cr, wr_timing, wr_count, wr_status;
    logic [31:0]   wmask;
    logic [31:0]   cr_cur, timing_cur, count_cur, status_cur;
    logic [31:0]   cr_new, timing_new, count_new;
    logic          start_wr, w1c, done_set, run_d;
    logic          unused_bits;

    assign widx       = ahb_addr[ADDRWIDTH-1:2] - BASE_VEC[ADDRWIDTH-1:2];
    assign sel_cr     = (widx == WW'(0));
    assign sel_timing = (widx == WW'(1));
    assign sel_count  = (widx == WW'(2));
    assign sel_status = (widx == WW'(3));
    assign wr_cr      = ahb_write_en & sel_cr;
    assign wr_timing  = ahb_write_en & sel_timing;
    assign wr_count   = ahb_write_en & sel_count;
    assign wr_status  = ahb_write_en & sel_status;

    assign wmask = {{8{ahb_byte_strobe[3]}}, {8{ahb_byte_strobe[2]}},
                    {8{ahb_byte_strobe[1]}}, {8{ahb_byte_strobe[0]}}};

    assign busy        = (state_q == S_RUN);
    assign done        = done_q;
    assign sclk_out    = sclk_q;
    assign sclk_setup  = setup_q;
    assign sclk_sample = samp_q;

    // Current register images, zero-extended to the 32-bit bus.
    always_comb begin
        cr_cur     = '0;
        cr_cur[0]  = en_q;
        cr_cur[1]  = cpol_q;
        timing_cur = '0;
        timing_cur[DIV_WIDTH-1:0] = div_q;
        timing_cur[16 +: DIV_WIDTH] = sample_q;
        count_cur  = '0;
        count_cur[CNT_WIDTH-1:0] = n_q;
        status_cur = '0;
        status_cur[0] = busy;
        status_cur[1] = done_q;
        status_cur[16 +: CNT_WIDTH] = rem_q;
    end

    // Byte-lane merge of write data into each register image.
    always_comb begin
        cr_new     = (cr_cur     & ~wmask) | (ahb_wdata & wmask);
        timing_new = (timing_cur & ~wmask) | (ahb_wdata & wmask);
        count_new  = (count_cur  & ~wmask) | (ahb_wdata & wmask);
    end

    assign unused_bits = ^{ahb_addr[1:0], cr_new, timing_new, count_new};

    // Next values of the software-visible fields; timing and count are frozen during a burst.
    always_comb begin
        en_d     = wr_cr ? cr_new[0] : en_q;
        cpol_d   = wr_cr ? cr_new[1] : cpol_q;
        div_d    = (wr_timing & ~busy) ? timing_new[DIV_WIDTH-1:0] : div_q;
        sample_d = (wr_timing & ~busy) ? timing_new[16 +: DIV_WIDTH] : sample_q;
        n_d      = (wr_count & ~busy) ? count_new[CNT_WIDTH-1:0] : n_q;
        start_wr = wr_cr & ahb_byte_strobe[0] & ahb_wdata[2];
        w1c      = wr_status & ahb_byte_strobe[0] & ahb_wdata[1];
    end

    // Burst FSM: phase counter, remaining-period counter and completion flag.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        done_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_wr && en_d) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    rem_d   = n_d;
                end
            end
            S_RUN: begin
                if (!en_d) begin
                    // Abort: leave RUN before any further strobe is emitted.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == {div_q, 1'b1}) begin
                    cnt_d = '0;
                    if (rem_q != '0) begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == CNT_WIDTH'(1)) begin
                            state_d  = S_IDLE;
                            done_set = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        done_d = done_set | (done_q & ~w1c);
    end

    // Output strobes are derived from the next phase so that they line up with cnt_q.
    always_comb begin
        run_d   = (state_d == S_RUN);
        sclk_d  = cpol_d ^ (run_d && (cnt_d > {1'b0, div_d}));
        setup_d = run_d && (cnt_d == {div_d, 1'b1});
        samp_d  = run_d && (cnt_d == {1'b0, sample_d});
    end

    // State and register file update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            cpol_q   <= 1'b0;
            div_q    <= '0;
            sample_q <= '0;
            n_q      <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            sclk_q   <= 1'b0;
            setup_q  <= 1'b0;
            samp_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            cpol_q   <= cpol_d;
            div_q    <= div_d;
            sample_q <= sample_d;
            n_q      <= n_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            sclk_q   <= sclk_d;
            setup_q  <= setup_d;
            samp_q   <= samp_d;
        end
    end

    // Combinational register read mux; unmapped words read zero.
    always_comb begin
        ahb_rdata = '0;
        if (ahb_read_en) begin
            if (sel_cr)          ahb_rdata = cr_cur;
            else if (sel_timing) ahb_rdata = timing_cur;
            else if (sel_count)  ahb_rdata = count_cur;
            else if (sel_status) ahb_rdata = status_cur;
        end
    end

endmodule

// File: tb/tb_dap_sclk_burst_gen.sv
// Directed bench for dap_sclk_burst_gen: register table plus burst, free-run, abort and W1C sequences.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// No backpressure; every wait is a fixed cycle count and a watchdog bounds the run.
module tb_dap_sclk_burst_gen;

    logic        clk;
    logic        resetn;
    logic        ahb_write_en;
    logic        ahb_read_en;
    logic [11:0] ahb_addr;
    logic [31:0] ahb_wdata;
    logic [3:0]  ahb_byte_strobe;
    logic [31:0] ahb_rdata;
    logic        sclk_out, sclk_setup, sclk_sample, busy, done;

    int errors = 0;
    int checks = 0;

    dap_sclk_burst_gen dut (
        .clk             (clk),
        .resetn          (resetn),
        .ahb_write_en    (ahb_write_en),
        .ahb_read_en     (ahb_read_en),
        .ahb_addr        (ahb_addr),
        .ahb_wdata       (ahb_wdata),
        .ahb_byte_strobe (ahb_byte_strobe),
        .ahb_rdata       (ahb_rdata),
        .sclk_out        (sclk_out),
        .sclk_setup      (sclk_setup),
        .sclk_sample     (sclk_sample),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [11:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        ahb_addr        = a;
        ahb_wdata       = d;
        ahb_byte_strobe = s;
        ahb_write_en    = 1'b1;
        @(negedge clk);
        ahb_write_en    = 1'b0;
        ahb_wdata       = '0;
        ahb_byte_strobe = '0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        ahb_addr    = a;
        ahb_read_en = 1'b1;
        #1;
        d = ahb_rdata;
        ahb_read_en = 1'b0;
    endtask

    // Expected waveform: for the first 'act' cycles a running burst with the given timing,
    // idle (sclk=CPOL, no strobes, not busy) afterwards. Starts at the current falling edge.
    task automatic expect_wave(input int ncyc, input int dv, input int sp, input bit cp, input int act);
        int ph;
        logic [3:0] e;
        for (int k = 0; k < ncyc; k++) begin
            if (k < act) begin
                ph = k % (2 * dv + 2);
                e  = {cp ^ (ph > dv), (ph == 2 * dv + 1), (ph == sp), 1'b1};
            end else begin
                e  = {cp, 1'b0, 1'b0, 1'b0};
            end
            chk($sformatf("wave{sclk,setup,sample,busy} k=%0d", k),
                {28'd0, sclk_out, sclk_setup, sclk_sample, busy}, {28'd0, e});
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] r;

        vecs[0] = '{1'b1, 12'h004, 32'h0003_0002, 4'hF, 12'h004, 32'h0003_0002};
        vecs[1] = '{1'b1, 12'h004, 32'hFFFF_0000, 4'hC, 12'h004, 32'hFFFF_0002};
        vecs[2] = '{1'b1, 12'h004, 32'h0000_1234, 4'h1, 12'h004, 32'hFFFF_0034};
        vecs[3] = '{1'b1, 12'h008, 32'h1234_5678, 4'hF, 12'h008, 32'h0000_5678};
        vecs[4] = '{1'b1, 12'h008, 32'h0000_AB00, 4'h2, 12'h00A, 32'h0000_AB78};
        vecs[5] = '{1'b1, 12'h000, 32'h0000_0003, 4'hF, 12'h000, 32'h0000_0003};
        vecs[6] = '{1'b1, 12'h000, 32'hFFFF_FFF8, 4'hF, 12'h000, 32'h0000_0000};
        vecs[7] = '{1'b0, 12'h000, 32'h0000_0000, 4'h0, 12'h010, 32'h0000_0000};
        vecs[8] = '{1'b0, 12'h000, 32'h0000_0000, 4'h0, 12'hFFC, 32'h0000_0000};
        vecs[9] = '{1'b1, 12'h00C, 32'h0000_0002, 4'hF, 12'h00C, 32'h0000_0000};

        resetn = 1'b0;
        ahb_write_en = 1'b0;
        ahb_read_en = 1'b0;
        ahb_addr = '0;
        ahb_wdata = '0;
        ahb_byte_strobe = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Reset state
        chk("reset outputs{sclk,setup,sample,busy,done}",
            {27'd0, sclk_out, sclk_setup, sclk_sample, busy, done}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd(12'(i * 4), r);
            chk($sformatf("reset reg%0d", i), r, 32'd0);
        end

        // Register access table
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) wr(vecs[i].waddr, vecs[i].wdata, vecs[i].strb);
            rd(vecs[i].raddr, r);
            chk($sformatf("regvec%0d", i), r, vecs[i].exp);
        end

        // START with EN=0 is ignored
        wr(12'h000, 32'h4, 4'hF);
        chk("start with EN=0 busy", {31'd0, busy}, 32'd0);

        // Burst: DIV=1, SAMPLE=1, N=3, CPOL=0
        wr(12'h004, 32'h0001_0001, 4'hF);
        wr(12'h008, 32'd3, 4'hF);
        wr(12'h000, 32'h1, 4'hF);
        wr(12'h000, 32'h5, 4'hF);
        expect_wave(16, 1, 1, 1'b0, 12);
        chk("burst1 done", {31'd0, done}, 32'd1);
        rd(12'h00C, r);
        chk("burst1 status", r, 32'h0000_0002);

        // DONE W1C in the completing cycle: set wins
        wr(12'h00C, 32'h2, 4'hF);
        chk("w1c clears done", {31'd0, done}, 32'd0);
        wr(12'h000, 32'h5, 4'hF);
        repeat (10) @(negedge clk);
        chk("busy before last cycle", {31'd0, busy}, 32'd1);
        wr(12'h00C, 32'h2, 4'hF);
        chk("set wins over w1c done", {31'd0, done}, 32'd1);
        chk("set wins over w1c busy", {31'd0, busy}, 32'd0);
        wr(12'h00C, 32'h2, 4'hF);
        chk("later w1c done", {31'd0, done}, 32'd0);

        // CPOL=1, DIV=0, SAMPLE=5, N=4: idles high, toggles every clk, no sample strobe
        wr(12'h004, 32'h0005_0000, 4'hF);
        wr(12'h008, 32'd4, 4'hF);
        wr(12'h000, 32'h3, 4'hF);
        chk("cpol idle high", {31'd0, sclk_out}, 32'd1);
        wr(12'h000, 32'h7, 4'hF);
        expect_wave(10, 0, 5, 1'b1, 8);
        chk("cpol burst done", {31'd0, done}, 32'd1);
        wr(12'h00C, 32'h2, 4'hF);

        // START while busy is ignored; remaining count keeps counting down
        wr(12'h004, 32'h0001_0001, 4'hF);
        wr(12'h008, 32'd5, 4'hF);
        wr(12'h000, 32'h5, 4'hF);
        repeat (5) @(negedge clk);
        wr(12'h000, 32'h5, 4'hF);
        rd(12'h00C, r);
        chk("restart ignored status", r, 32'h0004_0001);
        repeat (12) @(negedge clk);
        chk("restart ignored busy at end", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("restart ignored finishes", {30'd0, busy, done}, 32'h1);
        wr(12'h00C, 32'h2, 4'hF);

        // Free-run N=0, DIV=2, then abort with EN=0
        wr(12'h004, 32'h0000_0002, 4'hF);
        wr(12'h008, 32'd0, 4'hF);
        wr(12'h000, 32'h1, 4'hF);
        wr(12'h000, 32'h5, 4'hF);
        expect_wave(60, 2, 0, 1'b0, 60);
        wr(12'h004, 32'h0003_0007, 4'hF);
        rd(12'h004, r);
        chk("timing write while busy", r, 32'h0000_0002);
        wr(12'h008, 32'd9, 4'hF);
        rd(12'h008, r);
        chk("count write while busy", r, 32'd0);
        rd(12'h00C, r);
        chk("free-run status", r, 32'h0000_0001);
        wr(12'h000, 32'h0, 4'hF);
        chk("abort outputs{sclk,setup,sample,busy,done}",
            {27'd0, sclk_out, sclk_setup, sclk_sample, busy, done}, 32'd0);
        expect_wave(8, 2, 0, 1'b0, 0);

        // Reset mid-burst
        wr(12'h004, 32'h0001_0001, 4'hF);
        wr(12'h008, 32'd3, 4'hF);
        wr(12'h000, 32'h1, 4'hF);
        wr(12'h000, 32'h5, 4'hF);
        repeat (2) @(negedge clk);
        chk("pre-reset sclk high", {31'd0, sclk_out}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid-burst reset outputs", {27'd0, sclk_out, sclk_setup, sclk_sample, busy, done}, 32'd0);
        rd(12'h004, r);
        chk("mid-burst reset timing", r, 32'd0);
        rd(12'h000, r);
        chk("mid-burst reset cr", r, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
